// File: rtl/tt_ctrl_seq.sv
// rtl/tt_ctrl_seq.sv - valid/ready sequencer driving the mux controller select/enable pins
// Optional incremental select mode: define TT_CTRL_SEQ_INCR_EN.
module tt_ctrl_seq #(
  parameter int RST_W    = 4,
  parameter int PULSE_W  = 2,
  parameter int SETTLE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [9:0] req_addr,
  input  logic       req_ena,
  output logic       done,
  output logic [9:0] cur_addr,
  output logic       ctrl_sel_rst_n,
  output logic       ctrl_sel_inc,
  output logic       ctrl_ena
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_INC_H  = 3'd2;
  localparam logic [2:0] S_INC_L  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;

  localparam int CW = 16;
  localparam logic [CW-1:0] C_RST    = CW'(RST_W - 1);
  localparam logic [CW-1:0] C_PULSE  = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE_W - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_rem;
  logic          r_ena_lat;
  logic          r_ready;
  logic          r_done;
  logic [9:0]    r_cur;
  logic          r_sel_rst_n;
  logic          r_inc;
  logic          r_ena;

  logic       w_hs;
  logic       w_skip_rst;
  logic [9:0] w_diff;

  assign w_hs   = req_valid & r_ready;
  assign w_diff = req_addr - r_cur;

`ifdef TT_CTRL_SEQ_INCR_EN
  // Counting up from the current select is enough when the target is not behind it.
  assign w_skip_rst = (req_addr >= r_cur);
`else
  assign w_skip_rst = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_ena_lat   <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_cur       <= '0;
      r_sel_rst_n <= 1'b0;
      r_inc       <= 1'b0;
      r_ena       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sel_rst_n <= 1'b1;
          if (w_hs) begin
            r_ready   <= 1'b0;
            r_ena     <= 1'b0;
            r_ena_lat <= req_ena;
            if (w_skip_rst) begin
              if (w_diff == 10'd0) begin
                r_state <= S_SETTLE;
                r_cnt   <= C_SETTLE;
              end else begin
                r_state <= S_INC_H;
                r_cnt   <= C_PULSE;
                r_inc   <= 1'b1;
                r_cur   <= r_cur + 10'd1;
                r_rem   <= w_diff - 10'd1;
              end
            end else begin
              r_state     <= S_RST;
              r_cnt       <= C_RST;
              r_sel_rst_n <= 1'b0;
              r_cur       <= '0;
              r_rem       <= req_addr;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end

        S_RST: begin
          if (r_cnt == '0) begin
            r_sel_rst_n <= 1'b1;
            if (r_rem == 10'd0) begin
              r_state <= S_SETTLE;
              r_cnt   <= C_SETTLE;
            end else begin
              r_state <= S_INC_H;
              r_cnt   <= C_PULSE;
              r_inc   <= 1'b1;
              r_cur   <= r_cur + 10'd1;
              r_rem   <= r_rem - 10'd1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_INC_H: begin
          if (r_cnt == '0) begin
            r_state <= S_INC_L;
            r_cnt   <= C_PULSE;
            r_inc   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_INC_L: begin
          if (r_cnt == '0) begin
            if (r_rem == 10'd0) begin
              r_state <= S_SETTLE;
              r_cnt   <= C_SETTLE;
            end else begin
              r_state <= S_INC_H;
              r_cnt   <= C_PULSE;
              r_inc   <= 1'b1;
              r_cur   <= r_cur + 10'd1;
              r_rem   <= r_rem - 10'd1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_ena   <= r_ena_lat;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = r_ready;
  assign done           = r_done;
  assign cur_addr       = r_cur;
  assign ctrl_sel_rst_n = r_sel_rst_n;
  assign ctrl_sel_inc   = r_inc;
  assign ctrl_ena       = r_ena;

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// tb/tb_tt_ctrl_seq.sv - self-checking bench for tt_ctrl_seq (table vectors, corner sequences, random vs timeline model)
`timescale 1ns/1ps
module tb_tt_ctrl_seq;
  localparam int RST_W    = 4;
  localparam int PULSE_W  = 2;
  localparam int SETTLE_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [9:0] req_addr = '0;
  logic       req_ena = 1'b0;
  logic       req_ready;
  logic       done;
  logic [9:0] cur_addr;
  logic       ctrl_sel_rst_n;
  logic       ctrl_sel_inc;
  logic       ctrl_ena;

  tt_ctrl_seq #(.RST_W(RST_W), .PULSE_W(PULSE_W), .SETTLE_W(SETTLE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_ena(req_ena),
    .done(done), .cur_addr(cur_addr),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: each request is a schedule of (R reset cycles, n pulses from base, settle).
  bit m_pre = 1'b1;
  bit m_busy = 1'b0;
  bit m_ena = 1'b0;
  bit m_req_ena = 1'b0;
  int m_cur = 0;
  int m_T = 0, m_R = 0, m_base = 0, m_n = 0, m_A = 0;

  always @(negedge clk) begin
    int d, len, p, k, e_cur;
    bit e_sel, e_inc, e_ena, e_rdy, e_done, fin;
    fin = 1'b0;
    e_sel = 1'b0; e_inc = 1'b0; e_ena = 1'b0; e_rdy = 1'b0; e_done = 1'b0; e_cur = 0;
    if (!rst_n || m_pre) begin
      if (!rst_n) begin
        m_pre = 1'b1; m_busy = 1'b0; m_ena = 1'b0; m_cur = 0;
      end
    end else if (!m_busy) begin
      e_sel = 1'b1; e_ena = m_ena; e_rdy = 1'b1; e_cur = m_cur;
    end else begin
      d   = cyc - m_T;
      len = m_R + 2 * PULSE_W * m_n + SETTLE_W;
      e_sel = 1'b1;
      e_cur = m_base + m_n;
      if (d <= m_R) begin
        e_sel = 1'b0; e_cur = 0;
      end else if (d <= m_R + 2 * PULSE_W * m_n) begin
        p = d - 1 - m_R;
        k = p / (2 * PULSE_W);
        e_inc = ((p % (2 * PULSE_W)) < PULSE_W);
        e_cur = m_base + k + 1;
      end else if (d == len + 1) begin
        e_done = 1'b1; e_rdy = 1'b1; e_ena = m_req_ena; fin = 1'b1;
      end
    end
    chk("mon_sel_rst_n", ctrl_sel_rst_n, e_sel);
    chk("mon_sel_inc", ctrl_sel_inc, e_inc);
    chk("mon_ena", ctrl_ena, e_ena);
    chk("mon_req_ready", req_ready, e_rdy);
    chk("mon_done", done, e_done);
    chk("mon_cur_addr", cur_addr, e_cur);
    if (fin) begin
      m_busy = 1'b0; m_ena = m_req_ena; m_cur = m_base + m_n;
    end
    if (rst_n && !m_pre && !m_busy && req_valid) begin
      m_busy = 1'b1; m_T = cyc; m_A = int'(req_addr); m_req_ena = req_ena;
`ifdef TT_CTRL_SEQ_INCR_EN
      if (m_A >= m_cur) begin
        m_R = 0; m_base = m_cur; m_n = m_A - m_cur;
      end else begin
        m_R = RST_W; m_base = 0; m_n = m_A;
      end
`else
      m_R = RST_W; m_base = 0; m_n = m_A;
`endif
    end
    if (rst_n && m_pre) m_pre = 1'b0;
  end

  task automatic wait_done(output int dcyc, output int pulses, output int rstlow);
    bit prev;
    prev = 1'b0; pulses = 0; rstlow = 0; dcyc = -1;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (!ctrl_sel_rst_n) rstlow++;
      if (ctrl_sel_inc && !prev) pulses++;
      prev = ctrl_sel_inc;
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic run_req(input logic [9:0] a, input logic e, output int lat, output int pulses,
                         output int rstlow);
    int t0, dc;
    @(posedge clk); #2;
    req_valid = 1'b1; req_addr = a; req_ena = e; t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done(dc, pulses, rstlow);
    lat = (dc < 0) ? -1 : dc - t0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
  endtask

  typedef struct {
    logic [9:0] addr;
    logic       ena;
    int         lat;
    int         pulses;
    int         rstlow;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat, pulses, rstlow, t0, d1, d2, hit;
    bit prev;

`ifdef TT_CTRL_SEQ_INCR_EN
    tbl[0] = '{10'd5,    1'b1, 25,   5,    0};
    tbl[1] = '{10'd0,    1'b1, 9,    0,    4};
    tbl[2] = '{10'd3,    1'b0, 17,   3,    0};
    tbl[3] = '{10'd7,    1'b1, 21,   4,    0};
    tbl[4] = '{10'd2,    1'b1, 17,   2,    4};
    tbl[5] = '{10'd1023, 1'b1, 4089, 1021, 0};
`else
    tbl[0] = '{10'd5,    1'b1, 29,   5,    4};
    tbl[1] = '{10'd0,    1'b1, 9,    0,    4};
    tbl[2] = '{10'd3,    1'b0, 21,   3,    4};
    tbl[3] = '{10'd7,    1'b1, 37,   7,    4};
    tbl[4] = '{10'd2,    1'b1, 17,   2,    4};
    tbl[5] = '{10'd1023, 1'b1, 4101, 1023, 4};
`endif

    // Reset values, then the first edge after release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_cur_addr", cur_addr, 0);
    chk("rst_sel_rst_n", ctrl_sel_rst_n, 0);
    chk("rst_sel_inc", ctrl_sel_inc, 0);
    chk("rst_ena", ctrl_ena, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_sel_rst_n", ctrl_sel_rst_n, 1);
    chk("post_rst_ena", ctrl_ena, 0);

    for (int i = 0; i < 6; i++) begin
      run_req(tbl[i].addr, tbl[i].ena, lat, pulses, rstlow);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_pulses", i), pulses, tbl[i].pulses);
      chk($sformatf("vec%0d_rst_cycles", i), rstlow, tbl[i].rstlow);
      chk($sformatf("vec%0d_ena", i), ctrl_ena, tbl[i].ena);
      chk($sformatf("vec%0d_cur_addr", i), cur_addr, tbl[i].addr);
    end

    // A request held valid while busy is taken only in the done cycle.
    do_reset();
    @(posedge clk); #2;
    req_valid = 1'b1; req_addr = 10'd3; req_ena = 1'b0; t0 = cyc;
    @(posedge clk); #1;
    req_addr = 10'd4; req_ena = 1'b1;
    wait_done(d1, pulses, rstlow);
`ifdef TT_CTRL_SEQ_INCR_EN
    chk("held_first_latency", d1 - t0, 17);
`else
    chk("held_first_latency", d1 - t0, 21);
`endif
    chk("held_first_ena", ctrl_ena, 0);
    chk("held_first_cur", cur_addr, 3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done(d2, pulses, rstlow);
`ifdef TT_CTRL_SEQ_INCR_EN
    chk("held_second_latency", d2 - d1, 9);
`else
    chk("held_second_latency", d2 - d1, 25);
`endif
    chk("held_second_ena", ctrl_ena, 1);
    chk("held_second_cur", cur_addr, 4);

    // Reset asserted during pulse 2 of a 10-step sequence.
    do_reset();
    @(posedge clk); #2;
    req_valid = 1'b1; req_addr = 10'd10; req_ena = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    pulses = 0; prev = 1'b0; hit = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ctrl_sel_inc && !prev) pulses++;
      prev = ctrl_sel_inc;
      if (pulses == 3) begin
        hit = 1;
        break;
      end
    end
    chk("midrst_reach_pulse2", hit, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_sel_inc", ctrl_sel_inc, 0);
    chk("midrst_sel_rst_n", ctrl_sel_rst_n, 0);
    chk("midrst_cur_addr", cur_addr, 0);
    chk("midrst_ena", ctrl_ena, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_ready", req_ready, 1);
    run_req(10'd10, 1'b1, lat, pulses, rstlow);
`ifdef TT_CTRL_SEQ_INCR_EN
    chk("midrst_redo_latency", lat, 45);
`else
    chk("midrst_redo_latency", lat, 49);
`endif
    chk("midrst_redo_pulses", pulses, 10);
    chk("midrst_redo_cur", cur_addr, 10);
    chk("midrst_redo_ena", ctrl_ena, 1);

    // Random traffic, including requests presented while busy.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      req_valid = ($urandom % 4 == 0);
      req_addr  = ($urandom % 60 == 0) ? 10'd1023 : 10'($urandom_range(0, 40));
      req_ena   = 1'($urandom % 2);
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    hit = 0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (!m_busy) begin
        hit = 1;
        break;
      end
    end
    chk("random_drain", hit, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
